// File: rtl/endian_stream_pkg.sv
// Shared types and helpers for the endian swap stream: swap modes, lane sizes,
// and a generic in-lane element reverse used for both data bytes and keep bits.
package endian_stream_pkg;

  typedef enum logic [1:0] {
    PASS   = 2'd0,
    SWAP16 = 2'd1,
    SWAP32 = 2'd2,
    SWAP64 = 2'd3
  } mode_t;

  localparam int unsigned LANE16_BYTES   = 2;
  localparam int unsigned LANE32_BYTES   = 4;
  localparam int unsigned LANE64_BYTES   = 8;
  localparam int unsigned MAX_DATA_WIDTH = 512;
  localparam int unsigned IDX_W          = 9;

  // Reverses elem_bits-wide elements inside each lane of lane_elems elements.
  // Bytes use elem_bits=8, keep bits use elem_bits=1, so both see one permutation.
  function automatic logic [MAX_DATA_WIDTH-1:0] lane_reverse(
    input logic [MAX_DATA_WIDTH-1:0] vec,
    input int unsigned               elem_bits,
    input int unsigned               n_elems,
    input int unsigned               lane_elems
  );
    logic [MAX_DATA_WIDTH-1:0] r;
    int unsigned               src;
    r = vec;
    for (int unsigned i = 0; i < n_elems; i++) begin
      src = (i / lane_elems) * lane_elems + (lane_elems - 1 - (i % lane_elems));
      for (int unsigned b = 0; b < elem_bits; b++) begin
        r[IDX_W'(i * elem_bits + b)] = vec[IDX_W'(src * elem_bits + b)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/endian_skid_buf.sv
// Output register plus one-entry skid register; in_ready is registered and
// reflects only skid occupancy, so there is no combinational path from out_ready.
module endian_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] out_q, out_q_nxt;
  logic [WIDTH-1:0] skid_q, skid_q_nxt;
  logic             out_v, out_v_nxt;
  logic             skid_v, skid_v_nxt;
  logic             rdy_q;
  logic             in_fire;

  always_comb begin
    out_q_nxt  = out_q;
    out_v_nxt  = out_v;
    skid_q_nxt = skid_q;
    skid_v_nxt = skid_v;
    in_fire    = in_valid & rdy_q;
    if (out_ready || !out_v) begin
      // rdy_q is low whenever the skid holds a beat, so no new beat races it
      if (skid_v) begin
        out_q_nxt  = skid_q;
        out_v_nxt  = 1'b1;
        skid_v_nxt = 1'b0;
      end else begin
        out_v_nxt = in_fire;
        if (in_fire) out_q_nxt = in_data;
      end
    end else if (in_fire) begin
      skid_q_nxt = in_data;
      skid_v_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= '0;
      out_v  <= 1'b0;
      skid_q <= '0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      out_q  <= out_q_nxt;
      out_v  <= out_v_nxt;
      skid_q <= skid_q_nxt;
      skid_v <= skid_v_nxt;
      rdy_q  <= ~skid_v_nxt;
    end
  end

  assign in_ready  = rdy_q;
  assign out_data  = out_q;
  assign out_valid = out_v;

endmodule

// File: rtl/endian_swap_stream.sv
// AXI-stream byte-order swapper: per-packet mode, in-lane byte reverse of data
// and keep, one-cycle latency through a skid-buffered output stage.
module endian_swap_stream
  import endian_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode_i,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tkeep,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [KEEP_WIDTH-1:0] m_tkeep,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [31:0]           pkt_cnt
);

  localparam int unsigned PAYLOAD_W = DATA_WIDTH + KEEP_WIDTH + 1;

  logic                      first_beat;
  mode_t                     pkt_mode;
  mode_t                     eff_mode;
  logic                      s_fire;
  logic [MAX_DATA_WIDTH-1:0] data_ext, keep_ext;
  logic [MAX_DATA_WIDTH-1:0] data_sw, keep_sw;
  logic [PAYLOAD_W-1:0]      pl_in, pl_out;
  logic [31:0]               pkt_cnt_q;

  assign s_fire = s_tvalid & s_tready;

  // The first beat of a packet uses mode_i live; later beats use the latched copy
  always_comb begin
    eff_mode = first_beat ? mode_t'(mode_i) : pkt_mode;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_beat <= 1'b1;
      pkt_mode   <= PASS;
    end else if (s_fire) begin
      if (first_beat) pkt_mode <= mode_t'(mode_i);
      first_beat <= s_tlast;
    end
  end

  always_comb begin
    data_ext                   = '0;
    data_ext[DATA_WIDTH-1:0]   = s_tdata;
    keep_ext                   = '0;
    keep_ext[KEEP_WIDTH-1:0]   = s_tkeep;
    data_sw                    = data_ext;
    keep_sw                    = keep_ext;
    case (eff_mode)
      SWAP16: begin
        data_sw = lane_reverse(data_ext, 8, KEEP_WIDTH, LANE16_BYTES);
        keep_sw = lane_reverse(keep_ext, 1, KEEP_WIDTH, LANE16_BYTES);
      end
      SWAP32: begin
        data_sw = lane_reverse(data_ext, 8, KEEP_WIDTH, LANE32_BYTES);
        keep_sw = lane_reverse(keep_ext, 1, KEEP_WIDTH, LANE32_BYTES);
      end
      SWAP64: begin
        data_sw = lane_reverse(data_ext, 8, KEEP_WIDTH, LANE64_BYTES);
        keep_sw = lane_reverse(keep_ext, 1, KEEP_WIDTH, LANE64_BYTES);
      end
      default: begin
        data_sw = data_ext;
        keep_sw = keep_ext;
      end
    endcase
    pl_in = {s_tlast, keep_sw[KEEP_WIDTH-1:0], data_sw[DATA_WIDTH-1:0]};
  end

  endian_skid_buf #(
    .WIDTH(PAYLOAD_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (pl_in),
    .in_valid (s_tvalid),
    .in_ready (s_tready),
    .out_data (pl_out),
    .out_valid(m_tvalid),
    .out_ready(m_tready)
  );

  assign m_tdata = pl_out[DATA_WIDTH-1:0];
  assign m_tkeep = pl_out[DATA_WIDTH +: KEEP_WIDTH];
  assign m_tlast = pl_out[PAYLOAD_W-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
    end else if (m_tvalid && m_tready && m_tlast) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_endian_swap_stream.sv
// Scoreboard bench for endian_swap_stream at DATA_WIDTH=64: directed beats push
// hand-computed expectations; a monitor pops and compares on each output handshake.
module tb_endian_swap_stream;
  import endian_stream_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode_i;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tlast;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] pkt_cnt;

  endian_swap_stream #(
    .DATA_WIDTH(64)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode_i  (mode_i),
    .s_tdata (s_tdata),
    .s_tkeep (s_tkeep),
    .s_tlast (s_tlast),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .m_tdata (m_tdata),
    .m_tkeep (m_tkeep),
    .m_tlast (m_tlast),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .pkt_cnt (pkt_cnt)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    int unsigned cyc;
    logic        lat;
  } exp_t;

  localparam logic [63:0] D0 = 64'h0011223344556677;
  localparam logic [63:0] D1 = 64'h8899AABBCCDDEEFF;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic        rdy_edge = 1'b1;
  logic        stall_phase = 1'b0;
  logic        pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rdy_edge = s_tready;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Called at negedge+1; returns at negedge+1 after the beat is accepted.
  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l, input mode_t m,
                      input logic [63:0] ed, input logic [7:0] ek, input logic lat);
    int unsigned n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    mode_i   = m;
    while (!s_tready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!s_tready) begin
      chk("send_timeout", 64'(s_tready), 64'd1);
    end else begin
      sb.push_back('{ed, ek, l, cyc + 1, lat});
      @(negedge clk);
      #1;
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_remaining", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: samples at negedge+3, after drivers settle and before the next edge
  initial begin
    logic        prev_stall;
    logic [63:0] prev_d;
    logic [7:0]  prev_k;
    logic        prev_l;
    exp_t        e;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_k = '0;
    prev_l = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 64'(m_tvalid), 64'd1);
          chk("hold_data", m_tdata, prev_d);
          chk("hold_keep", 64'(m_tkeep), 64'(prev_k));
          chk("hold_last", 64'(m_tlast), 64'(prev_l));
        end
        if (stall_phase) chk("s_tready_registered", 64'(s_tready), 64'(rdy_edge));
        if (m_tvalid && m_tready) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", 64'(m_tvalid), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("m_tdata", m_tdata, e.d);
            chk("m_tkeep", 64'(m_tkeep), 64'(e.k));
            chk("m_tlast", 64'(m_tlast), 64'(e.l));
            if (e.lat) chk("latency_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_d = m_tdata;
        prev_k = m_tkeep;
        prev_l = m_tlast;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    mode_i   = 2'd0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tdata", m_tdata, 64'd0);
    chk("rst_m_tkeep", 64'(m_tkeep), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd1);

    // Single-beat packets in every mode, back to back, latency checked
    send(D0, 8'hFF, 1'b1, SWAP64, 64'h7766554433221100, 8'hFF, 1'b1);
    send(D0, 8'hFF, 1'b1, SWAP32, 64'h3322110077665544, 8'hFF, 1'b1);
    send(D0, 8'hFF, 1'b1, SWAP16, 64'h1100332255447766, 8'hFF, 1'b1);
    send(D0, 8'hFF, 1'b1, PASS,   D0,                   8'hFF, 1'b1);
    drain();
    chk("pkt_cnt_after_modes", 64'(pkt_cnt), 64'd4);

    // Keep follows its byte; all-zero keep beat still passes
    send(D0, 8'h0F, 1'b1, SWAP64, 64'h7766554433221100, 8'hF0, 1'b0);
    send(D0, 8'h01, 1'b1, SWAP16, 64'h1100332255447766, 8'h02, 1'b0);
    send(D1, 8'h00, 1'b1, SWAP32, 64'hBBAA9988FFEEDDCC, 8'h00, 1'b0);

    // Mode change mid-packet applies only from the next packet
    send(D0, 8'hFF, 1'b0, SWAP64, 64'h7766554433221100, 8'hFF, 1'b0);
    send(D1, 8'hFF, 1'b0, SWAP64, 64'hFFEEDDCCBBAA9988, 8'hFF, 1'b0);
    send(D0, 8'hFF, 1'b0, PASS,   64'h7766554433221100, 8'hFF, 1'b0);
    send(D1, 8'hFF, 1'b1, PASS,   64'hFFEEDDCCBBAA9988, 8'hFF, 1'b0);
    send(D0, 8'hFF, 1'b1, PASS,   D0,                   8'hFF, 1'b0);
    drain();
    chk("pkt_cnt_after_mode_pkts", 64'(pkt_cnt), 64'd9);

    // 10-beat stream with m_tready toggling 1,0,0,1,0,...
    stall_phase = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          m_tready = pat[i % 5];
          @(negedge clk);
          #1;
        end
        m_tready = 1'b1;
      end
      begin
        for (int unsigned i = 0; i < 10; i++) begin
          send(64'hA5A5_0000_0000_0000 + 64'(i), 8'hFF, (i == 9), PASS,
               64'hA5A5_0000_0000_0000 + 64'(i), 8'hFF, 1'b0);
        end
      end
    join
    drain();
    stall_phase = 1'b0;
    chk("pkt_cnt_after_stream", 64'(pkt_cnt), 64'd10);

    // Reset mid-packet with the skid full
    m_tready = 1'b0;
    send(D0, 8'hFF, 1'b0, SWAP64, 64'h7766554433221100, 8'hFF, 1'b0);
    send(D1, 8'hFF, 1'b0, SWAP64, 64'hFFEEDDCCBBAA9988, 8'hFF, 1'b0);
    chk("skid_full_s_tready", 64'(s_tready), 64'd0);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("midrst_s_tready", 64'(s_tready), 64'd1);
    m_tready = 1'b1;
    send(D0, 8'hFF, 1'b1, SWAP16, 64'h1100332255447766, 8'hFF, 1'b0);
    drain();
    chk("pkt_cnt_after_rst_pkt", 64'(pkt_cnt), 64'd1);

    // Counter wrap
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_cnt_q;
    send(D1, 8'hFF, 1'b1, PASS, D1, 8'hFF, 1'b0);
    drain();
    chk("pkt_cnt_wrap", 64'(pkt_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/endian_swap_stream.md
ENDIAN_SWAP_STREAM -- requirements
Module: endian_swap_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, beat width in bits; legal values are multiples of 64, from 64 to 512.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, byte-enable width; it is derived and not overridden.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port mode_i, input, 2 bits: swap mode. 0 = pass, 1 = swap16, 2 = swap32, 3 = swap64.
REQ-006 SHALL have port s_tdata, input, DATA_WIDTH: input beat data.
REQ-007 SHALL have port s_tkeep, input, KEEP_WIDTH: input byte enables, one per byte.
REQ-008 SHALL have ports s_tlast (input, 1), s_tvalid (input, 1) and s_tready (output, 1): input stream control.
REQ-009 SHALL have ports m_tdata (output, DATA_WIDTH), m_tkeep (output, KEEP_WIDTH), m_tlast (output, 1), m_tvalid (output, 1) and m_tready (input, 1): output stream.
REQ-010 SHALL have port pkt_cnt, output, 32 bits: count of packets completed at the output.

Function
REQ-011 SHALL reverse byte order independently inside every lane of the selected size: 16, 32 or 64 bits. Pass mode leaves data unchanged. Byte 0 is s_tdata[7:0].
REQ-012 SHALL apply the identical byte permutation to tkeep, so each keep bit follows its byte.
REQ-013 SHALL pass tlast through unchanged.
REQ-014 SHALL accept an input beat when s_tvalid and s_tready are both 1, and SHALL emit an output beat when m_tvalid and m_tready are both 1.
REQ-015 SHALL have 1-cycle latency: a beat accepted in cycle N is presented on m_* in cycle N+1, provided the output register is empty or being drained.
REQ-016 SHALL sustain one beat per cycle while m_tready stays 1.
REQ-017 SHALL include a 1-entry skid register. When m_tready=0 while the output register is full, an in-flight accepted beat is parked there.
REQ-018 SHALL drive s_tready as a registered signal equal to "skid register empty", with no combinational path from m_tready.
REQ-019 SHALL emit beats strictly in acceptance order. When the skid is occupied, the skid beat is forwarded before any new beat.
REQ-020 SHALL hold m_tdata, m_tkeep and m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-021 SHALL sample mode_i only on the first beat of a packet and SHALL use that sampled mode for every beat up to and including the beat with tlast.
  - First beat = first accepted beat after reset, or the first accepted beat after a tlast beat.
  - A mode_i change mid-packet takes effect only from the next packet.
REQ-022 SHALL treat a single-beat packet (tlast on its first beat) as using mode_i sampled on that beat.
REQ-023 SHALL increment pkt_cnt by 1 on each output handshake with m_tlast=1. It wraps from 0xFFFFFFFF to 0 with no flag.
REQ-024 SHALL pass a beat with s_tkeep all zero through as a normal beat, without dropping it.

Reset
REQ-025 SHALL, in any cycle where rst_n=0 at the clk edge, set:
  - m_tvalid = 0
  - skid register empty, and s_tready = 1 from the first cycle after reset
  - pkt_cnt = 0
  - first-beat flag = 1
  - m_tdata and m_tkeep = 0
REQ-026 SHALL discard any in-flight or skid beat on reset; a partially transferred packet is not completed.

Structure
REQ-027 SHALL put the following in shared package endian_stream_pkg:
  - the mode typedef (enum: PASS, SWAP16, SWAP32, SWAP64)
  - lane-size constants
  - a width-generic lane byte-reverse function used for both data and keep
REQ-028 SHALL place the skid-buffer/output-register pair in one sub-module, endian_skid_buf, parameterised by payload width.
REQ-029 SHALL implement the permutation in the top module as combinational logic ahead of endian_skid_buf.

Verification
REQ-030 With DATA_WIDTH=64, m_tready=1, a single beat 0x0011223344556677, keep 0xFF, tlast=1, the bench SHALL check:
  - swap64 gives 0x7766554433221100
  - swap32 gives 0x3322110077665544
  - swap16 gives 0x1100332255447766
  - pass gives the input unchanged
  - each result appears 1 cycle after acceptance
REQ-031 With DATA_WIDTH=64, swap64, keep 0x0F, the bench SHALL check m_tkeep=0xF0; with swap16 and keep 0x01 it SHALL check m_tkeep=0x02.
REQ-032 For a 4-beat packet started with mode_i=3, where mode_i changes to 0 at beat 2, the bench SHALL check that all 4 beats are swap64 and that the next packet is pass.
REQ-033 For a 10-beat stream with m_tready toggling 1,0,0,1,0,1..., the bench SHALL check:
  - all 10 beats arrive in order with no loss or duplication
  - s_tready never depends combinationally on m_tready
  - m_* stays stable while stalled
REQ-034 With rst_n asserted mid-packet while the skid is full, the bench SHALL check m_tvalid=0 and pkt_cnt=0 the next cycle, and that the following packet samples a new mode.
REQ-035 With pkt_cnt forced to 0xFFFFFFFF, the bench SHALL check that one more packet yields pkt_cnt=0.
